// File: rtl/activity_session_tracker.sv
// Multi-activity session tracker: start/stop/clear session FSM, 1 s prescaler,
// per-channel seconds and MET*weight calorie accumulators with sticky saturation flags.
module activity_session_tracker #(
    parameter int                 N_ACT       = 3,
    parameter int                 CLK_PER_SEC = 1000,
    parameter int                 SEC_W       = 16,
    parameter int                 CAL_W       = 24,
    parameter int                 WEIGHT_W    = 8,
    parameter logic [N_ACT*8-1:0] MET_TABLE   = {8'd10, 8'd5, 8'd8}
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              stop,
    input  logic                              clear,
    input  logic [N_ACT-1:0]                  act_req,
    input  logic [WEIGHT_W-1:0]               weight,
    input  logic [$clog2(N_ACT)-1:0]          rd_sel,
    output logic [1:0]                        state,
    output logic [N_ACT-1:0]                  act_cur,
    output logic                              tick,
    output logic [SEC_W-1:0]                  rd_seconds,
    output logic [CAL_W-1:0]                  rd_calories,
    output logic [SEC_W+$clog2(N_ACT)-1:0]    total_seconds,
    output logic [N_ACT-1:0]                  sat
);

    localparam int SEL_W  = $clog2(N_ACT);
    localparam int PRE_W  = $clog2(CLK_PER_SEC);
    localparam int PROD_W = 8 + WEIGHT_W;
    localparam int SUM_W  = ((CAL_W > PROD_W) ? CAL_W : PROD_W) + 1;
    localparam int TOT_W  = SEC_W + SEL_W;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_SEC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PRE_W-1:0]   r_presc;
    logic [PRE_W-1:0]   w_presc_nxt;
    logic               r_tick;
    logic               w_tick_nxt;
    logic [N_ACT-1:0]   r_act_cur;
    logic [N_ACT-1:0]   w_act_nxt;
    logic [N_ACT-1:0]   r_sat;
    logic [N_ACT-1:0]   w_credit;
    logic [N_ACT-1:0]   w_cal_ovf;
    logic [N_ACT-1:0]   w_sec_full;
    logic [SEC_W-1:0]   r_sec     [N_ACT];
    logic [CAL_W-1:0]   r_cal     [N_ACT];
    logic [SUM_W-1:0]   w_prod    [N_ACT];
    logic [SUM_W-1:0]   w_cal_sum [N_ACT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // clear beats stop beats start; a stop in IDLE/PAUSE also masks a same-cycle start.
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (start && !stop) w_state_nxt = ST_RUN;
                ST_RUN:   if (stop)           w_state_nxt = ST_PAUSE;
                ST_PAUSE: if (start && !stop) w_state_nxt = ST_RUN;
                default:                      w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_tick_nxt  = (r_state == ST_RUN) && (r_presc == PRE_MAX) && !clear;
        w_presc_nxt = r_presc;
        if (clear) begin
            w_presc_nxt = '0;
        end else begin
            case (r_state)
                ST_RUN:   w_presc_nxt = w_tick_nxt ? '0 : r_presc + PRE_W'(1);
                ST_PAUSE: w_presc_nxt = r_presc;
                default:  w_presc_nxt = '0;
            endcase
        end
    end

    // Isolate the lowest set request bit: fixed priority towards channel 0.
    assign w_act_nxt = act_req & (~act_req + N_ACT'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc   <= '0;
            r_tick    <= 1'b0;
            r_act_cur <= '0;
        end else begin
            r_presc   <= w_presc_nxt;
            r_tick    <= w_tick_nxt;
            r_act_cur <= w_act_nxt;
        end
    end

    assign w_credit = {N_ACT{w_tick_nxt}} & r_act_cur;

    always_comb begin
        for (int i = 0; i < N_ACT; i++) begin
            w_prod[i]     = SUM_W'(MET_TABLE[i*8 +: 8]) * SUM_W'(weight);
            w_cal_sum[i]  = SUM_W'(r_cal[i]) + w_prod[i];
            w_cal_ovf[i]  = |w_cal_sum[i][SUM_W-1:CAL_W];
            w_sec_full[i] = &r_sec[i];
        end
    end

    // sat marks a credit that had to be clamped, in either counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_ACT; i++) begin
                r_sec[i] <= '0;
                r_cal[i] <= '0;
            end
            r_sat <= '0;
        end else if (clear) begin
            for (int i = 0; i < N_ACT; i++) begin
                r_sec[i] <= '0;
                r_cal[i] <= '0;
            end
            r_sat <= '0;
        end else begin
            for (int i = 0; i < N_ACT; i++) begin
                if (w_credit[i]) begin
                    if (!w_sec_full[i]) begin
                        r_sec[i] <= r_sec[i] + SEC_W'(1);
                    end
                    r_cal[i] <= w_cal_ovf[i] ? '1 : w_cal_sum[i][CAL_W-1:0];
                    if (w_sec_full[i] || w_cal_ovf[i]) begin
                        r_sat[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_seconds    = '0;
        rd_calories   = '0;
        total_seconds = '0;
        for (int i = 0; i < N_ACT; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_seconds  = r_sec[i];
                rd_calories = r_cal[i];
            end
            total_seconds = total_seconds + TOT_W'(r_sec[i]);
        end
    end

    assign state   = r_state;
    assign act_cur = r_act_cur;
    assign tick    = r_tick;
    assign sat     = r_sat;

endmodule

// File: tb/tb_activity_session_tracker.sv
// Directed bench for activity_session_tracker with CLK_PER_SEC=4; a second
// instance with SEC_W=4 shares the stimulus and is used for seconds saturation.
module tb_activity_session_tracker;

    localparam int N_ACT = 3;
    localparam int CPS   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        clear;
    logic [2:0]  act_req;
    logic [7:0]  weight;
    logic [1:0]  rd_sel;

    logic [1:0]  state;
    logic [2:0]  act_cur;
    logic        tick;
    logic [15:0] rd_seconds;
    logic [23:0] rd_calories;
    logic [17:0] total_seconds;
    logic [2:0]  sat;

    logic [1:0]  state4;
    logic [2:0]  act_cur4;
    logic        tick4;
    logic [3:0]  rd_seconds4;
    logic [23:0] rd_calories4;
    logic [5:0]  total_seconds4;
    logic [2:0]  sat4;

    int n_chk  = 0;
    int n_pass = 0;
    int tick_cnt;

    activity_session_tracker #(.N_ACT(N_ACT), .CLK_PER_SEC(CPS)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .act_req(act_req), .weight(weight), .rd_sel(rd_sel),
        .state(state), .act_cur(act_cur), .tick(tick),
        .rd_seconds(rd_seconds), .rd_calories(rd_calories),
        .total_seconds(total_seconds), .sat(sat)
    );

    activity_session_tracker #(.N_ACT(N_ACT), .CLK_PER_SEC(CPS), .SEC_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .act_req(act_req), .weight(weight), .rd_sel(rd_sel),
        .state(state4), .act_cur(act_cur4), .tick(tick4),
        .rd_seconds(rd_seconds4), .rd_calories(rd_calories4),
        .total_seconds(total_seconds4), .sat(sat4)
    );

    // clock/reset block
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_ch(input string tag, input logic [1:0] ch,
                            input logic [31:0] exp_sec, input logic [31:0] exp_cal);
        rd_sel = ch;
        #1;
        chk({tag, "_sec"}, rd_seconds, exp_sec);
        chk({tag, "_cal"}, rd_calories, exp_cal);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        act_req = 3'b111; weight = 8'd0; rd_sel = 2'd0;
        step(2);
        chk("rst_state", state, 0);
        chk("rst_tick", tick, 0);
        chk("rst_act_cur", act_cur, 0);
        chk("rst_sat", sat, 0);
        chk("rst_total", total_seconds, 0);
        check_ch("rst_ch0", 2'd0, 0, 0);
        rst = 1'b1; act_req = 3'b000;
        step(1);

        // T1: ch0 at weight 70 for 40 cycles -> 10 s, 560 kcal units per second
        act_req = 3'b001; weight = 8'd70; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t1_run", state, 1);
        chk("t1_act_cur", act_cur, 3'b001);
        step(3);
        chk("t1_no_early_tick", tick, 0);
        step(1);
        chk("t1_first_tick", tick, 1);
        check_ch("t1_one", 2'd0, 1, 560);
        step(1);
        chk("t1_tick_pulse", tick, 0);
        step(35);
        check_ch("t1_ch0", 2'd0, 10, 5600);
        chk("t1_total", total_seconds, 10);
        do_clear();
        chk("t1_clr_state", state, 0);
        check_ch("t1_clr_ch0", 2'd0, 0, 0);

        // T2: multi-hot request, ch1 wins, MET 5 * 60 per tick
        act_req = 3'b110; weight = 8'd60; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t2_act_cur", act_cur, 3'b010);
        step(12);
        check_ch("t2_ch1", 2'd1, 3, 900);
        check_ch("t2_ch2", 2'd2, 0, 0);
        check_ch("t2_ch0", 2'd0, 0, 0);
        chk("t2_total", total_seconds, 3);
        do_clear();

        // T3: pause with prescaler at 2, resume gives a tick 2 cycles later
        act_req = 3'b001; weight = 8'd50; start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        chk("t3_tick1", tick, 1);
        step(1);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        chk("t3_pause", state, 2);
        tick_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (tick) tick_cnt++;
        end
        chk("t3_paused_ticks", tick_cnt, 0);
        check_ch("t3_paused_ch0", 2'd0, 1, 400);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t3_resume", state, 1);
        chk("t3_resume_tick0", tick, 0);
        step(1);
        chk("t3_resume_tick1", tick, 0);
        step(1);
        chk("t3_resume_tick2", tick, 1);
        check_ch("t3_ch0", 2'd0, 2, 800);
        do_clear();

        // T4: 20 ticks; the 4-bit instance clamps at 15 and flags sat
        act_req = 3'b001; weight = 8'd1; start = 1'b1;
        step(1);
        start = 1'b0;
        step(80);
        rd_sel = 2'd0;
        #1;
        chk("t4_sec4", rd_seconds4, 15);
        chk("t4_cal4", rd_calories4, 160);
        chk("t4_sat4", sat4, 3'b001);
        chk("t4_sec16", rd_seconds, 20);
        chk("t4_sat16", sat, 3'b000);
        check_ch("t4_sel3", 2'd3, 0, 0);
        rd_sel = 2'd0;
        do_clear();
        #1;
        chk("t4_clr_sec4", rd_seconds4, 0);
        chk("t4_clr_sat4", sat4, 3'b000);
        chk("t4_clr_state4", state4, 0);
        chk("t4_clr_total4", total_seconds4, 0);

        // T5: start+stop in IDLE ignored; start in RUN ignored; clear+start -> IDLE
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        chk("t5_ss_idle", state, 0);
        act_req = 3'b001; weight = 8'd10; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t5_run", state, 1);
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t5_start_in_run", state, 1);
        step(2);
        chk("t5_tick_kept", tick, 1);
        check_ch("t5_ch0", 2'd0, 1, 80);
        clear = 1'b1; start = 1'b1;
        step(1);
        clear = 1'b0; start = 1'b0;
        chk("t5_clr_state", state, 0);
        check_ch("t5_clr_ch0", 2'd0, 0, 0);
        chk("t5_clr_total", total_seconds, 0);
        step(5);
        chk("t5_idle_state", state, 0);
        chk("t5_idle_tick", tick, 0);

        // T6: async reset mid-RUN, then ticks with no active channel
        act_req = 3'b001; weight = 8'd20; start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        chk("t6_tick_before", tick, 1);
        rst = 1'b0;
        #1;
        chk("t6_rst_state", state, 0);
        chk("t6_rst_tick", tick, 0);
        chk("t6_rst_act_cur", act_cur, 0);
        chk("t6_rst_total", total_seconds, 0);
        check_ch("t6_rst_ch0", 2'd0, 0, 0);
        step(1);
        rst = 1'b1; act_req = 3'b000; start = 1'b1;
        step(1);
        start = 1'b0;
        chk("t6_act_none", act_cur, 0);
        step(4);
        chk("t6_tick_idle_ch", tick, 1);
        chk("t6_total", total_seconds, 0);
        chk("t6_sat", sat, 0);
        check_ch("t6_ch0", 2'd0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
